// File: rtl/fetch_prefetch_if.sv
// Handshake bundle between the fetch stage, instruction memory and decode.
interface fetch_prefetch_if #(
   parameter int unsigned XLEN = 32
);
   logic            imem_req_valid;
   logic            imem_req_ready;
   logic [XLEN-1:0] imem_req_addr;
   logic            imem_rsp_valid;
   logic [31:0]     imem_rsp_data;
   logic            ir_valid;
   logic            ir_ready;
   logic [XLEN-1:0] pc;
   logic [31:0]     ir;

   modport master (
      output imem_req_valid, imem_req_addr, ir_valid, pc, ir,
      input  imem_req_ready, imem_rsp_valid, imem_rsp_data, ir_ready
   );

   modport slave (
      input  imem_req_valid, imem_req_addr, ir_valid, pc, ir,
      output imem_req_ready, imem_rsp_valid, imem_rsp_data, ir_ready
   );
endinterface

// File: rtl/fetch_prefetch.sv
// Instruction-fetch stage: in-order prefetch queue between a valid/ready
// instruction memory and decode. Redirects flush the queue and discard the
// responses of requests that were still in flight.
module fetch_prefetch #(
   parameter int unsigned     XLEN      = 32,
   parameter int unsigned     DEPTH     = 4,
   parameter logic [XLEN-1:0] BOOT_ADDR = '0,
   parameter logic [31:0]     NOP       = 32'h0000_0013
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             redirect,
   input  logic [XLEN-1:0]  redirect_pc,
   output logic             misaligned,
   fetch_prefetch_if.master bus
);
   localparam int unsigned   IW      = $clog2(DEPTH);
   localparam int unsigned   CW      = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   typedef enum logic {ST_RUN, ST_HALT} state_t;

   state_t          state_q, state_d;
   logic [XLEN-1:0] fpc_q, fpc_d;
   logic [IW-1:0]   head_q, head_d;
   logic [IW-1:0]   tail_q, tail_d;
   logic [IW-1:0]   fill_q, fill_d;
   logic [CW-1:0]   count_q, count_d;
   logic [CW-1:0]   infl_q, infl_d;
   logic [CW-1:0]   drop_q, drop_d;

   logic [XLEN-1:0]  qpc_q [DEPTH];
   logic [31:0]      qir_q [DEPTH];
   logic [DEPTH-1:0] filled_q;

   logic req_valid, accept, rsp_take, rsp_fill, head_valid, pop;

   // Handshake decode for the current cycle. infl_q counts every outstanding
   // response (live and to-be-dropped), so it also bounds requests in flight.
   always_comb begin
      req_valid  = resetn & ~redirect & (state_q == ST_RUN)
                 & (count_q < DEPTH_C) & (infl_q < DEPTH_C);
      accept     = req_valid & bus.imem_req_ready;
      rsp_take   = bus.imem_rsp_valid & (infl_q != '0);
      rsp_fill   = rsp_take & (drop_q == '0);
      head_valid = resetn & (count_q != '0) & filled_q[head_q];
      pop        = head_valid & bus.ir_ready;
   end

   assign bus.imem_req_valid = req_valid;
   assign bus.imem_req_addr  = fpc_q;
   assign bus.ir_valid       = head_valid;
   assign bus.ir             = head_valid ? qir_q[head_q] : NOP;
   assign bus.pc             = head_valid ? qpc_q[head_q] : '0;
   assign misaligned         = (state_q == ST_HALT);

   // Pointer, counter and fetch-PC next state; a redirect overrides pop/alloc/fill.
   always_comb begin
      state_d = state_q;
      fpc_d   = fpc_q;
      head_d  = head_q;
      tail_d  = tail_q;
      fill_d  = fill_q;
      count_d = count_q;
      infl_d  = infl_q;
      drop_d  = drop_q;
      if (redirect) begin
         head_d  = '0;
         tail_d  = '0;
         fill_d  = '0;
         count_d = '0;
         // Everything still outstanding after this cycle's response becomes stale.
         infl_d  = infl_q - CW'(rsp_take);
         drop_d  = infl_q - CW'(rsp_take);
         fpc_d   = redirect_pc;
         state_d = (redirect_pc[1:0] != 2'b00) ? ST_HALT : ST_RUN;
      end else begin
         if (accept) begin
            tail_d = tail_q + IW'(1);
            fpc_d  = fpc_q + XLEN'(4);
         end
         if (pop) begin
            head_d = head_q + IW'(1);
         end
         if (rsp_fill) begin
            fill_d = fill_q + IW'(1);
         end
         count_d = count_q + CW'(accept) - CW'(pop);
         infl_d  = infl_q + CW'(accept) - CW'(rsp_take);
         if (rsp_take && (drop_q != '0)) begin
            drop_d = drop_q - CW'(1);
         end
      end
   end

   // State registers and queue storage.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q  <= ST_RUN;
         fpc_q    <= BOOT_ADDR;
         head_q   <= '0;
         tail_q   <= '0;
         fill_q   <= '0;
         count_q  <= '0;
         infl_q   <= '0;
         drop_q   <= '0;
         filled_q <= '0;
      end else begin
         state_q <= state_d;
         fpc_q   <= fpc_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         fill_q  <= fill_d;
         count_q <= count_d;
         infl_q  <= infl_d;
         drop_q  <= drop_d;
         if (redirect) begin
            filled_q <= '0;
         end else begin
            if (accept) begin
               qpc_q[tail_q]    <= fpc_q;
               filled_q[tail_q] <= 1'b0;
            end
            if (rsp_fill) begin
               qir_q[fill_q]    <= bus.imem_rsp_data;
               filled_q[fill_q] <= 1'b1;
            end
         end
      end
   end

   // Outstanding-response and occupancy counters never exceed the queue depth.
   assert property (@(posedge clk) disable iff (!resetn)
      (infl_q <= DEPTH_C) && (drop_q <= infl_q) && (count_q <= DEPTH_C));

endmodule
